// File: rtl/hazard_fwd_if.sv
// ---------------------------------------------------------------------------
// hazard_fwd_if
//   Bundle between the decode stage of the 5-stage MIPS pipeline and the
//   hazard/forwarding controller.
//
//   Decode -> controller (driven by master):
//     d_rs, d_rt            D-stage source register indices
//     d_tuse_rs, d_tuse_rt  cycles until the operand is consumed (3 = unused)
//     d_dst                 D-stage destination register (0 = no write)
//     d_res                 result kind: 0 NONE, 1 ALU, 2 DM, 3 PC8
//     d_md_start, d_md_div  instruction starts mult/div, and which kind
//     d_md_use              instruction touches HI/LO or the mult/div unit
//   Controller -> pipeline (driven by slave):
//     stall, flush_e        freeze PC/F-D and insert bubble into D/E
//     fwd_rs_d, fwd_rt_d    D operand selects
//     fwd_rs_e, fwd_rt_e    E operand selects
//     fwd_rt_m              M store-data select
//     md_busy               mult/div unit still computing
// ---------------------------------------------------------------------------
interface hazard_fwd_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic [1:0]        d_tuse_rs;
    logic [1:0]        d_tuse_rt;
    logic [REG_AW-1:0] d_dst;
    logic [1:0]        d_res;
    logic              d_md_start;
    logic              d_md_div;
    logic              d_md_use;

    logic              stall;
    logic              flush_e;
    logic [2:0]        fwd_rs_d;
    logic [2:0]        fwd_rt_d;
    logic [2:0]        fwd_rs_e;
    logic [2:0]        fwd_rt_e;
    logic              fwd_rt_m;
    logic              md_busy;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_res,
               d_md_start, d_md_div, d_md_use,
        input  stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
               fwd_rt_m, md_busy
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_res,
               d_md_start, d_md_div, d_md_use,
        output stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
               fwd_rt_m, md_busy
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl
//   Pipelined hazard and forwarding controller for the F/D/E/M/W MIPS core.
//   Keeps its own E/M/W copy of the register tags, derives Tnew per stage,
//   compares it with the D-stage Tuse to decide stalls, produces forwarding
//   selects for D rs/rt, E rs/rt and M rt, and tracks the multi-cycle
//   mult/div unit so HI/LO users wait for it.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset; clears all tags and the counter
//     hz     hazard_fwd_if.slave (D-stage tags in, stall/forward selects out)
//
//   Forward select encoding: 0 REG, 1 E_PC8, 2 M_ALU, 3 M_PC8, 4 W_RES.
//   Only fields that some decision reads are kept per stage: M needs rt for
//   store-data forwarding, W only needs dst/res.
// ---------------------------------------------------------------------------
module hazard_fwd_ctrl #(
    parameter int REG_AW   = 5,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    hazard_fwd_if.slave hz
);

    localparam logic [1:0] RES_NONE  = 2'd0;
    localparam logic [1:0] RES_ALU   = 2'd1;
    localparam logic [1:0] RES_DM    = 2'd2;
    localparam logic [1:0] RES_PC8   = 2'd3;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [2:0] SEL_REG   = 3'd0;
    localparam logic [2:0] SEL_E_PC8 = 3'd1;
    localparam logic [2:0] SEL_M_ALU = 3'd2;
    localparam logic [2:0] SEL_M_PC8 = 3'd3;
    localparam logic [2:0] SEL_W_RES = 3'd4;

    // E stage tags
    logic [REG_AW-1:0] e_rs_p0;
    logic [REG_AW-1:0] e_rt_p0;
    logic [REG_AW-1:0] e_dst_p0;
    logic [1:0]        e_res_p0;
    logic              e_md_start_p0;
    logic              e_md_div_p0;
    // M stage tags
    logic [REG_AW-1:0] m_rt_p1;
    logic [REG_AW-1:0] m_dst_p1;
    logic [1:0]        m_res_p1;
    // W stage tags
    logic [REG_AW-1:0] w_dst_p2;
    logic [1:0]        w_res_p2;

    logic [CNT_W-1:0]  md_cnt;
    logic              md_busy_w;
    logic              data_stall;
    logic              md_stall;
    logic              stall_w;

    // A stage "holds" src when it writes that register with a real result.
    function automatic logic hit(input logic [REG_AW-1:0] src,
                                 input logic [REG_AW-1:0] dst,
                                 input logic [1:0]        res);
        return (src != '0) && (src == dst) && (res != RES_NONE);
    endfunction

    function automatic logic [1:0] tnew_e(input logic [1:0] res);
        case (res)
            RES_ALU: return 2'd1;
            RES_DM:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] tnew_m(input logic [1:0] res);
        return (res == RES_DM) ? 2'd1 : 2'd0;
    endfunction

    // Only the nearest producer matters; W always has Tnew 0 so it never stalls.
    function automatic logic src_stall(input logic [REG_AW-1:0] src,
                                       input logic [1:0]        tuse,
                                       input logic [REG_AW-1:0] e_dst,
                                       input logic [1:0]        e_res,
                                       input logic [REG_AW-1:0] m_dst,
                                       input logic [1:0]        m_res);
        logic st;
        st = 1'b0;
        if (tuse != TUSE_NONE) begin
            if (hit(src, e_dst, e_res))
                st = (tnew_e(e_res) > tuse);
            else if (hit(src, m_dst, m_res))
                st = (tnew_m(m_res) > tuse);
        end
        return st;
    endfunction

    // Nearest of M/W. An M load result is not yet available, so it selects REG;
    // the stall logic guarantees it is never actually consumed.
    function automatic logic [2:0] sel_mw(input logic [REG_AW-1:0] src,
                                          input logic [REG_AW-1:0] m_dst,
                                          input logic [1:0]        m_res,
                                          input logic [REG_AW-1:0] w_dst,
                                          input logic [1:0]        w_res);
        logic [2:0] sel;
        sel = SEL_REG;
        if (hit(src, m_dst, m_res)) begin
            if (m_res == RES_ALU)
                sel = SEL_M_ALU;
            else if (m_res == RES_PC8)
                sel = SEL_M_PC8;
        end else if (hit(src, w_dst, w_res)) begin
            sel = SEL_W_RES;
        end
        return sel;
    endfunction

    // An E producer shadows M/W; only its PC+8 value is ready this early.
    function automatic logic [2:0] sel_d(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] e_dst,
                                         input logic [1:0]        e_res,
                                         input logic [REG_AW-1:0] m_dst,
                                         input logic [1:0]        m_res,
                                         input logic [REG_AW-1:0] w_dst,
                                         input logic [1:0]        w_res);
        if (hit(src, e_dst, e_res))
            return (e_res == RES_PC8) ? SEL_E_PC8 : SEL_REG;
        return sel_mw(src, m_dst, m_res, w_dst, w_res);
    endfunction

    assign data_stall = src_stall(hz.d_rs, hz.d_tuse_rs, e_dst_p0, e_res_p0, m_dst_p1, m_res_p1)
                      | src_stall(hz.d_rt, hz.d_tuse_rt, e_dst_p0, e_res_p0, m_dst_p1, m_res_p1);

    assign md_busy_w = (md_cnt != '0);
    // A mult/div sitting in E has not loaded the counter yet, so it counts as busy.
    assign md_stall  = hz.d_md_use & (md_busy_w | e_md_start_p0);
    assign stall_w   = data_stall | md_stall;

    assign hz.stall    = stall_w;
    assign hz.flush_e  = stall_w;
    assign hz.md_busy  = md_busy_w;
    assign hz.fwd_rs_d = sel_d(hz.d_rs, e_dst_p0, e_res_p0, m_dst_p1, m_res_p1, w_dst_p2, w_res_p2);
    assign hz.fwd_rt_d = sel_d(hz.d_rt, e_dst_p0, e_res_p0, m_dst_p1, m_res_p1, w_dst_p2, w_res_p2);
    assign hz.fwd_rs_e = sel_mw(e_rs_p0, m_dst_p1, m_res_p1, w_dst_p2, w_res_p2);
    assign hz.fwd_rt_e = sel_mw(e_rt_p0, m_dst_p1, m_res_p1, w_dst_p2, w_res_p2);
    assign hz.fwd_rt_m = hit(m_rt_p1, w_dst_p2, w_res_p2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_rs_p0       <= '0;
            e_rt_p0       <= '0;
            e_dst_p0      <= '0;
            e_res_p0      <= RES_NONE;
            e_md_start_p0 <= 1'b0;
            e_md_div_p0   <= 1'b0;
            m_rt_p1       <= '0;
            m_dst_p1      <= '0;
            m_res_p1      <= RES_NONE;
            w_dst_p2      <= '0;
            w_res_p2      <= RES_NONE;
            md_cnt        <= '0;
        end else begin
            // ---- D -> E: stalled instruction stays in D, E gets a bubble ----
            if (stall_w) begin
                e_rs_p0       <= '0;
                e_rt_p0       <= '0;
                e_dst_p0      <= '0;
                e_res_p0      <= RES_NONE;
                e_md_start_p0 <= 1'b0;
                e_md_div_p0   <= 1'b0;
            end else begin
                e_rs_p0       <= hz.d_rs;
                e_rt_p0       <= hz.d_rt;
                e_dst_p0      <= hz.d_dst;
                e_res_p0      <= hz.d_res;
                e_md_start_p0 <= hz.d_md_start;
                e_md_div_p0   <= hz.d_md_div;
            end
            // ---- E -> M ----
            m_rt_p1  <= e_rt_p0;
            m_dst_p1 <= e_dst_p0;
            m_res_p1 <= e_res_p0;
            // ---- M -> W ----
            w_dst_p2 <= m_dst_p1;
            w_res_p2 <= m_res_p1;
            // ---- mult/div busy counter: a new start reloads over the countdown ----
            if (e_md_start_p0)
                md_cnt <= e_md_div_p0 ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
//   Directed stimulus for hazard_fwd_ctrl. A reference model keeps the last
//   three issued instructions (E/M/W) as plain records plus a mult/div
//   "busy until cycle" deadline, and a compare process checks every output
//   against it on each falling edge. Hand-computed literal checks pin the
//   scenarios from the test plan.
// ---------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

    localparam int REG_AW   = 5;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int CNT_W    = 4;

    localparam logic [1:0] NONE = 2'd0;
    localparam logic [1:0] ALU  = 2'd1;
    localparam logic [1:0] DM   = 2'd2;
    localparam logic [1:0] PC8  = 2'd3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    hazard_fwd_if #(.REG_AW(REG_AW)) hz ();

    hazard_fwd_ctrl #(
        .REG_AW  (REG_AW),
        .MULT_LAT(MULT_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic [1:0] res;
        logic       md_start;
        logic       md_div;
    } mtag_t;

    mtag_t       mp [3] = '{default: '0};   // 0 = E, 1 = M, 2 = W
    int unsigned cyc      = 0;
    int unsigned busy_end = 0;
    // Cycles until a produced value is available, indexed [stage][result kind].
    int          tnew_tab [3][4] = '{'{0, 1, 2, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 0}};

    function automatic int nearest(input logic [4:0] src, input int from);
        for (int s = from; s < 3; s++)
            if (src != 5'd0 && mp[s].dst == src && mp[s].res != NONE) return s;
        return -1;
    endfunction

    function automatic logic [2:0] exp_sel(input logic [4:0] src, input int from);
        int n;
        n = nearest(src, from);
        if (n == 2) return 3'd4;
        if (n == 1) return (mp[1].res == ALU) ? 3'd2 : (mp[1].res == PC8) ? 3'd3 : 3'd0;
        if (n == 0) return (mp[0].res == PC8) ? 3'd1 : 3'd0;
        return 3'd0;
    endfunction

    function automatic logic exp_src_stall(input logic [4:0] src, input logic [1:0] tuse);
        int n;
        if (tuse == 2'd3) return 1'b0;
        n = nearest(src, 0);
        return (n >= 0) && (tnew_tab[n][mp[n].res] > int'(tuse));
    endfunction

    function automatic logic exp_busy();
        return cyc < busy_end;
    endfunction

    function automatic logic exp_stall();
        return exp_src_stall(hz.d_rs, hz.d_tuse_rs) | exp_src_stall(hz.d_rt, hz.d_tuse_rt)
             | (hz.d_md_use & (exp_busy() | mp[0].md_start));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mp[0]    <= '0;
            mp[1]    <= '0;
            mp[2]    <= '0;
            busy_end <= 0;
        end else begin
            if (mp[0].md_start)
                busy_end <= cyc + (mp[0].md_div ? DIV_LAT : MULT_LAT) + 1;
            mp[2] <= mp[1];
            mp[1] <= mp[0];
            if (exp_stall()) mp[0] <= '0;
            else mp[0] <= mtag_t'({hz.d_rs, hz.d_rt, hz.d_dst, hz.d_res, hz.d_md_start, hz.d_md_div});
            cyc <= cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_stall",    32'(hz.stall),    32'(exp_stall()));
        chk("cmp_flush_e",  32'(hz.flush_e),  32'(exp_stall()));
        chk("cmp_md_busy",  32'(hz.md_busy),  32'(exp_busy()));
        chk("cmp_fwd_rs_d", 32'(hz.fwd_rs_d), 32'(exp_sel(hz.d_rs, 0)));
        chk("cmp_fwd_rt_d", 32'(hz.fwd_rt_d), 32'(exp_sel(hz.d_rt, 0)));
        chk("cmp_fwd_rs_e", 32'(hz.fwd_rs_e), 32'(exp_sel(mp[0].rs, 1)));
        chk("cmp_fwd_rt_e", 32'(hz.fwd_rt_e), 32'(exp_sel(mp[0].rt, 1)));
        chk("cmp_fwd_rt_m", 32'(hz.fwd_rt_m), 32'(nearest(mp[1].rt, 2) == 2));
    end

    // ---------------- stimulus ----------------
    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] trs, input logic [1:0] trt,
                         input logic [4:0] dst, input logic [1:0] res,
                         input logic mds, input logic mdd, input logic mdu);
        hz.d_rs = rs;  hz.d_rt = rt;  hz.d_tuse_rs = trs;  hz.d_tuse_rt = trt;
        hz.d_dst = dst;  hz.d_res = res;
        hz.d_md_start = mds;  hz.d_md_div = mdd;  hz.d_md_use = mdu;
    endtask

    task automatic nop();
        set_d(0, 0, 3, 3, 0, NONE, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drain();
        nop();
        repeat (4) tick();
    endtask

    // Counts stall cycles of an HI/LO user that follows a mult/div start.
    task automatic md_run(input logic is_div, input int want, input string name);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        set_d(11, 12, 0, 0, 0, NONE, 1, is_div, 1);
        tick();
        set_d(0, 0, 3, 3, 13, ALU, 0, 0, 1);
        for (int i = 0; i < 40 && !done; i++) begin
            at_neg();
            if (hz.stall) begin
                n++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
        chk({name, "_bound"}, 32'(done), 32'd1);
        chk({name, "_stall_cycles"}, 32'(n), 32'(want));
        chk({name, "_idle_after"}, 32'(hz.md_busy), 32'd0);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        nop();
        tick();
        chk("rst_stall",    32'(hz.stall),    32'd0);
        chk("rst_flush",    32'(hz.flush_e),  32'd0);
        chk("rst_md_busy",  32'(hz.md_busy),  32'd0);
        chk("rst_fwd_rs_e", 32'(hz.fwd_rs_e), 32'd0);
        chk("rst_fwd_rt_m", 32'(hz.fwd_rt_m), 32'd0);
        rst_n = 1'b1;
        drain();

        // lw $1 ; addu $2,$1,$3 -> one load-use stall, then W forward in E
        set_d(2, 0, 1, 3, 1, DM, 0, 0, 0);
        tick();
        set_d(1, 3, 1, 1, 2, ALU, 0, 0, 0);
        at_neg();
        chk("lw_use_stall", 32'(hz.stall),   32'd1);
        chk("lw_use_flush", 32'(hz.flush_e), 32'd1);
        tick();
        at_neg();
        chk("lw_use_resume", 32'(hz.stall), 32'd0);
        tick();
        nop();
        at_neg();
        chk("lw_use_fwd_e", 32'(hz.fwd_rs_e), 32'd4);
        drain();

        // addu $1 in M, beq $1 in D
        set_d(3, 4, 1, 1, 1, ALU, 0, 0, 0);
        tick();
        nop();
        tick();
        set_d(1, 4, 0, 0, 0, NONE, 0, 0, 0);
        at_neg();
        chk("beq_alu_stall", 32'(hz.stall),    32'd0);
        chk("beq_alu_fwd",   32'(hz.fwd_rs_d), 32'd2);
        drain();
        // lw $1 in M, beq $1 in D
        set_d(2, 0, 1, 3, 1, DM, 0, 0, 0);
        tick();
        nop();
        tick();
        set_d(1, 4, 0, 0, 0, NONE, 0, 0, 0);
        at_neg();
        chk("beq_lw_stall", 32'(hz.stall), 32'd1);
        drain();

        // jal in E, jr $31 in D
        set_d(0, 0, 3, 3, 31, PC8, 0, 0, 0);
        tick();
        set_d(31, 0, 0, 3, 0, NONE, 0, 0, 0);
        at_neg();
        chk("jr_pc8_stall", 32'(hz.stall),    32'd0);
        chk("jr_pc8_fwd",   32'(hz.fwd_rs_d), 32'd1);
        drain();
        // PC8 producer with dst 0, reader of $0
        set_d(0, 0, 3, 3, 0, PC8, 0, 0, 0);
        tick();
        set_d(0, 0, 0, 3, 0, NONE, 0, 0, 0);
        at_neg();
        chk("jr_r0_stall", 32'(hz.stall),    32'd0);
        chk("jr_r0_fwd",   32'(hz.fwd_rs_d), 32'd0);
        drain();

        // $5 written by lw (reaches W) and addu (in E); E shadows W
        set_d(6, 0, 1, 3, 5, DM, 0, 0, 0);
        tick();
        nop();
        tick();
        set_d(7, 8, 1, 1, 5, ALU, 0, 0, 0);
        tick();
        set_d(5, 9, 1, 1, 10, ALU, 0, 0, 0);
        at_neg();
        chk("b2b_stall", 32'(hz.stall),    32'd0);
        chk("b2b_fwd_d", 32'(hz.fwd_rs_d), 32'd0);
        tick();
        nop();
        at_neg();
        chk("b2b_fwd_e", 32'(hz.fwd_rs_e), 32'd2);
        drain();

        // mult/div occupancy
        md_run(1'b1, 1 + DIV_LAT,  "div");
        md_run(1'b0, 1 + MULT_LAT, "mult");

        // Reset in the middle: counter at 7, lw in E, M-stage ALU forward live
        set_d(11, 12, 0, 0, 0, NONE, 1, 1, 1);   // div
        tick();
        nop();
        tick();
        tick();
        set_d(0, 0, 3, 3, 4, ALU, 0, 0, 0);      // addu $4
        tick();
        set_d(2, 0, 1, 3, 1, DM, 0, 0, 0);       // lw $1
        tick();
        set_d(1, 4, 0, 0, 3, ALU, 0, 0, 1);      // reads $1, $4 and HI/LO
        at_neg();
        chk("pre_rst_stall",   32'(hz.stall),    32'd1);
        chk("pre_rst_busy",    32'(hz.md_busy),  32'd1);
        chk("pre_rst_fwd_rt",  32'(hz.fwd_rt_d), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall",   32'(hz.stall),    32'd0);
        chk("mid_rst_flush",   32'(hz.flush_e),  32'd0);
        chk("mid_rst_busy",    32'(hz.md_busy),  32'd0);
        chk("mid_rst_fwd_rs",  32'(hz.fwd_rs_d), 32'd0);
        chk("mid_rst_fwd_rt",  32'(hz.fwd_rt_d), 32'd0);
        #1;
        rst_n = 1'b1;
        #0.5;
        chk("post_rst_stall",  32'(hz.stall),    32'd0);
        chk("post_rst_fwd_rt", 32'(hz.fwd_rt_d), 32'd0);
        tick();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipelined hazard and forwarding controller for the 5-stage MIPS core (F/D/E/M/W). Successor to the combinational forwarding mux selector.
- Holds its own E/M/W tag pipeline (source regs, destination, result kind). Derives Tnew per stage, compares against D-stage Tuse, and issues stall/bubble.
- Generates forwarding selects for D rs/rt, E rs/rt and M rt.
- Tracks a multi-cycle mult/div unit with a busy counter and stalls HI/LO users.

Parameters:
- REG_AW, 5, register-index width; index 0 is never forwarded or stalled on.
- MULT_LAT, 5, cycles mult/div stays busy after a mult starts.
- DIV_LAT, 10, cycles busy after a div starts.
- CNT_W, 4, busy-counter width; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- d_rs  in  REG_AW  D-stage rs index
- d_rt  in  REG_AW  D-stage rt index
- d_tuse_rs  in  2  cycles until rs is consumed (0=D, 1=E, 2=M, 3=unused)
- d_tuse_rt  in  2  same for rt
- d_dst  in  REG_AW  D-stage destination (0 = no write)
- d_res  in  2  result kind: 0 NONE, 1 ALU, 2 DM, 3 PC8
- d_md_start  in  1  D instr starts mult/div
- d_md_div  in  1  1=div, 0=mult; valid with d_md_start
- d_md_use  in  1  D instr reads/writes HI/LO or starts mult/div
- stall  out  1  freeze PC and F/D register
- flush_e  out  1  load bubble into D/E register (equals stall)
- fwd_rs_d, fwd_rt_d  out  3  D operand select
- fwd_rs_e, fwd_rt_e  out  3  E operand select
- fwd_rt_m  out  1  M store-data select: 0 reg, 1 W result
- md_busy  out  1  busy counter nonzero

Behaviour:
- Select encoding (3-bit): 0 REG, 1 E_PC8, 2 M_ALU, 3 M_PC8, 4 W_RES.
- Tag pipeline: E, M, W each hold {rs, rt, dst, res}. All are cleared to 0/NONE on rst_n low, asynchronously.
- Each clock: W<=M and M<=E unconditionally. E<=D inputs when stall=0; E<=bubble (all zero, res NONE) when stall=1.
- Tnew by stage:
  - E: ALU=1, DM=2, PC8=0
  - M: ALU=0, DM=1, PC8=0
  - W: 0 for all kinds
  - res NONE never matches.
- Match at a stage: src==stage.dst, src!=0, and stage.res!=NONE.
- Data stall: for rs or rt with tuse!=3, the nearest matching stage (E before M before W) has Tnew > tuse.
- MD stall: d_md_use=1 and (md_busy=1 or E-stage tag carries md_start).
  - E carries one extra bit, e_md_start, loaded from d_md_start&~stall.
- stall = data stall | MD stall. flush_e = stall. Both are purely combinational from tags and D inputs, so both are 0 after reset.
- D forward select, nearest match only:
  - E match with PC8 -> 1.
  - M match with ALU -> 2; M match with PC8 -> 3.
  - W match -> 4.
  - Otherwise 0.
  - If the nearest match is not ready, stall is asserted and the select value is don't-care (drive 0).
- E forward select (rs_e/rt_e from E tags):
  - M match with ALU -> 2; M match with PC8 -> 3.
  - W match -> 4.
  - Otherwise 0.
  - An M match with DM cannot occur, because the stall prevents it.
- M forward: fwd_rt_m=1 when M.rt matches W.
- Busy counter:
  - Load happens when e_md_start=1 (instr enters E): cnt<=DIV_LAT if div, else MULT_LAT. The kind bit travels with the E tag.
  - Otherwise cnt decrements while nonzero. Decrement is independent of stall.
  - md_busy = (cnt!=0). Reset 0.
  - A load in the same cycle as the decrement-to-zero wins, i.e. the counter reloads.
- Reset mid-operation: all tags, the counter and e_md_start clear immediately. Outputs go to 0 within the same delta.

Test Plan:
- lw $1 then addu $2,$1,$3 with tuse_rs=1: one stall cycle (stall=1, flush_e=1). Next cycle fwd_rs_e=4.
- addu $1 in M (ALU), beq with rs=$1 in D (tuse 0): stall=0, fwd_rs_d=2. Same sequence with lw in M: stall=1.
- jal in E (dst 31, PC8), jr $31 in D: stall=0, fwd_rs_d=1. Same with dst=0: fwd=0, no stall.
- Back-to-back writers: $5 in both E (ALU) and W (DM), D reads $5 with tuse 1. E match wins over W, Tnew=1 <= 1: no stall, fwd_rs_d=0. The next cycle shows fwd_rs_e=2.
- div issued, then mfhi in D: stall stays high until the counter reaches 0, i.e. 1 cycle for e_md_start plus DIV_LAT cycles. mult with MULT_LAT=5 gives 1+5 cycles.
- Assert rst_n=0 with cnt=7 and an lw in E: stall, md_busy and all selects go to 0 immediately. After release, tags stay cleared.
